// File: rtl/mem_access_unit_if.sv
// Bundle of request/response and data_memory signals for mem_access_unit.
// The slave modport is the unit's view; master is the view of whatever
// sits around it (execute stage, writeback and data_memory together).
interface mem_access_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              misalign;
    logic [ADDR_W-1:0] Mem_addr;
    logic [DATA_W-1:0] RF_Rd_data;
    logic              CNTRL_write_en;
    logic [DATA_W-1:0] Mem_data;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, Mem_data,
        output req_ready, resp_valid, resp_rdata, misalign, Mem_addr, RF_Rd_data, CNTRL_write_en
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, Mem_data,
        input  req_ready, resp_valid, resp_rdata, misalign, Mem_addr, RF_Rd_data, CNTRL_write_en
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-wide, one-cycle-latency data_memory.
// Sub-word stores are done as read-modify-write; loads are lane-selected and
// sign/zero extended. All outputs come straight from flops.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned requests skip memory and
// complete with misalign=1. Without it, misaligned addresses are forced aligned.
module mem_access_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD, CAPT, WR} state_t;

    state_t            state_q, state_d;
    logic              opWe_q, opWe_d;
    logic [1:0]        opSize_q, opSize_d;
    logic              opSigned_q, opSigned_d;
    logic [1:0]        opLane_q, opLane_d;
    logic [15:0]       opWdata_q, opWdata_d;
    logic              trap_q, trap_d;
    logic              reqReady_q, reqReady_d;
    logic              respValid_q, respValid_d;
    logic [DATA_W-1:0] respRdata_q, respRdata_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic              writeEn_q, writeEn_d;

    logic              misalignReq;
    logic [1:0]        acceptLane;
    logic [7:0]        laneByte;
    logic [15:0]       laneHalf;
    logic [DATA_W-1:0] loadResult;
    logic [DATA_W-1:0] mergedWord;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalignReq = (bus.req_size == 2'b01) ? bus.req_addr[0] :
                         (bus.req_size[1] ? (bus.req_addr[1:0] != 2'b00) : 1'b0);
`else
    assign misalignReq = 1'b0;
`endif

    // Lane of the incoming request, with the low address bits that do not
    // matter for halves/words dropped so the access is naturally aligned.
    always_comb begin
        acceptLane = 2'b00;
        if (bus.req_size == 2'b00) begin
            acceptLane = bus.req_addr[1:0];
        end else if (bus.req_size == 2'b01) begin
            acceptLane = {bus.req_addr[1], 1'b0};
        end
    end

    // Pick the addressed byte/half out of the word just read back.
    always_comb begin
        laneByte = bus.Mem_data[7:0];
        case (opLane_q)
            2'd1:    laneByte = bus.Mem_data[15:8];
            2'd2:    laneByte = bus.Mem_data[23:16];
            2'd3:    laneByte = bus.Mem_data[31:24];
            default: laneByte = bus.Mem_data[7:0];
        endcase
        laneHalf = opLane_q[1] ? bus.Mem_data[31:16] : bus.Mem_data[15:0];
    end

    // Extend the selected lane into the load result; word loads pass through.
    always_comb begin
        loadResult = bus.Mem_data;
        if (opSize_q == 2'b00) begin
            loadResult = {{24{opSigned_q & laneByte[7]}}, laneByte};
        end else if (opSize_q == 2'b01) begin
            loadResult = {{16{opSigned_q & laneHalf[15]}}, laneHalf};
        end
    end

    // Overlay the store lane(s) onto the read word, leaving other bytes alone.
    always_comb begin
        mergedWord = bus.Mem_data;
        if (opSize_q == 2'b00) begin
            case (opLane_q)
                2'd1:    mergedWord[15:8]  = opWdata_q[7:0];
                2'd2:    mergedWord[23:16] = opWdata_q[7:0];
                2'd3:    mergedWord[31:24] = opWdata_q[7:0];
                default: mergedWord[7:0]   = opWdata_q[7:0];
            endcase
        end else if (opLane_q[1]) begin
            mergedWord[31:16] = opWdata_q;
        end else begin
            mergedWord[15:0] = opWdata_q;
        end
    end

    // Sequencer next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        opWe_d      = opWe_q;
        opSize_d    = opSize_q;
        opSigned_d  = opSigned_q;
        opLane_d    = opLane_q;
        opWdata_d   = opWdata_q;
        trap_d      = trap_q;
        memAddr_d   = memAddr_q;
        wrData_d    = wrData_q;
        respValid_d = 1'b0;
        respRdata_d = '0;
        misalign_d  = 1'b0;
        writeEn_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && reqReady_q) begin
                    opWe_d     = bus.req_we;
                    opSize_d   = bus.req_size;
                    opSigned_d = bus.req_signed;
                    opLane_d   = acceptLane;
                    opWdata_d  = bus.req_wdata[15:0];
                    trap_d     = misalignReq;
                    memAddr_d  = bus.req_addr[ADDR_W+1:2];
                    if (misalignReq) begin
                        state_d = WR;
                    end else if (bus.req_we && bus.req_size[1]) begin
                        state_d   = WR;
                        wrData_d  = bus.req_wdata;
                        writeEn_d = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = CAPT;
            end
            CAPT: begin
                if (opWe_q) begin
                    wrData_d  = mergedWord;
                    writeEn_d = 1'b1;
                    state_d   = WR;
                end else begin
                    respValid_d = 1'b1;
                    respRdata_d = loadResult;
                    state_d     = IDLE;
                end
            end
            WR: begin
                respValid_d = 1'b1;
                misalign_d  = trap_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        reqReady_d = (state_d == IDLE);
    end

    // State, latched request fields and output flops; reset abandons any
    // in-flight request and kills the write strobe immediately.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            opWe_q      <= 1'b0;
            opSize_q    <= 2'b00;
            opSigned_q  <= 1'b0;
            opLane_q    <= 2'b00;
            opWdata_q   <= '0;
            trap_q      <= 1'b0;
            reqReady_q  <= 1'b1;
            respValid_q <= 1'b0;
            respRdata_q <= '0;
            misalign_q  <= 1'b0;
            memAddr_q   <= '0;
            wrData_q    <= '0;
            writeEn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            opWe_q      <= opWe_d;
            opSize_q    <= opSize_d;
            opSigned_q  <= opSigned_d;
            opLane_q    <= opLane_d;
            opWdata_q   <= opWdata_d;
            trap_q      <= trap_d;
            reqReady_q  <= reqReady_d;
            respValid_q <= respValid_d;
            respRdata_q <= respRdata_d;
            misalign_q  <= misalign_d;
            memAddr_q   <= memAddr_d;
            wrData_q    <= wrData_d;
            writeEn_q   <= writeEn_d;
        end
    end

    assign bus.req_ready      = reqReady_q;
    assign bus.resp_valid     = respValid_q;
    assign bus.resp_rdata     = respRdata_q;
    assign bus.misalign       = misalign_q;
    assign bus.Mem_addr       = memAddr_q;
    assign bus.RF_Rd_data     = wrData_q;
    assign bus.CNTRL_write_en = writeEn_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases from the block's worked examples,
// reset-in-flight cases, then randomized back-to-back traffic checked against
// a byte-level memory reference model.
module tb_mem_access_unit;

    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectorCount = 0;
    int   missCount = 0;
    int   strobeCount = 0;

    logic [31:0] memModel [0:65535];
    logic [31:0] refMem [0:15];

    mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // data_memory stand-in: synchronous write, read data one cycle after address.
    always @(posedge clk) begin
        if (bus.CNTRL_write_en) begin
            memModel[bus.Mem_addr] <= bus.RF_Rd_data;
            strobeCount <= strobeCount + 1;
        end
        bus.Mem_data <= memModel[bus.Mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] refLoad(input int addr, input int nb, input bit sgn);
        int a;
        logic [63:0] word, mask, val;
        a = addr - (addr % nb);
        word = {32'd0, refMem[a / 4]};
        mask = (64'd1 << (8 * nb)) - 64'd1;
        val = (word >> (8 * (a % 4))) & mask;
        if (nb < 4 && sgn && ((val >> (8 * nb - 1)) & 64'd1) != 64'd0)
            val = val | ~mask;
        return val[31:0];
    endfunction

    function automatic void refStore(input int addr, input int nb, input logic [31:0] wdata);
        int a, sh;
        logic [63:0] mask, merged;
        a = addr - (addr % nb);
        sh = 8 * (a % 4);
        mask = ((64'd1 << (8 * nb)) - 64'd1) << sh;
        merged = ({32'd0, refMem[a / 4]} & ~mask) | (({32'd0, wdata} << sh) & mask);
        refMem[a / 4] = merged[31:0];
    endfunction

    task automatic scrambleInputs();
        bus.req_we     = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = 18'($urandom);
        bus.req_wdata  = $urandom;
    endtask

    // Called at a negedge with the unit idle; returns at the negedge where
    // resp_valid is seen, so an immediate next call is a back-to-back request.
    task automatic applyStimulus(input bit we, input logic [1:0] size, input bit sgn,
                                 input int addr, input logic [31:0] wdata);
        int nb, expLat, expWr, cyc, wrSeen, wordIdx;
        bit expMis, gotResp;
        logic [31:0] expRdata, expWord, wrAddr, wrData;
        nb = (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
        expMis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        expMis = (addr % nb) != 0;
`endif
        wordIdx = addr / 4;
        expRdata = 32'd0;
        if (expMis) begin
            expLat = 2;
            expWr = 0;
        end else if (we) begin
            refStore(addr, nb, wdata);
            expLat = (nb == 4) ? 2 : 4;
            expWr = 1;
        end else begin
            expRdata = refLoad(addr, nb, sgn);
            expLat = 3;
            expWr = 0;
        end
        expWord = refMem[wordIdx];

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = 18'(addr);
        bus.req_wdata  = wdata;
        checkOutput("ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        scrambleInputs();

        cyc = 0;
        wrSeen = 0;
        gotResp = 1'b0;
        wrAddr = 32'd0;
        wrData = 32'd0;
        while (!gotResp && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (bus.CNTRL_write_en) begin
                wrSeen++;
                wrAddr = 32'(bus.Mem_addr);
                wrData = bus.RF_Rd_data;
            end
            if (bus.resp_valid) begin
                gotResp = 1'b1;
            end else begin
                checkOutput("ready_busy", 32'(bus.req_ready), 32'd0);
                if (!expMis)
                    checkOutput("mem_addr", 32'(bus.Mem_addr), 32'(wordIdx));
                scrambleInputs();
                bus.req_valid = 1'($urandom_range(0, 1));
            end
        end
        bus.req_valid = 1'b0;

        checkOutput("resp_seen", 32'(gotResp), 32'd1);
        checkOutput("latency", 32'(cyc), 32'(expLat));
        checkOutput("resp_rdata", bus.resp_rdata, expRdata);
        checkOutput("misalign", 32'(bus.misalign), 32'(expMis));
        checkOutput("ready_resp", 32'(bus.req_ready), 32'd1);
        checkOutput("strobe_count", 32'(wrSeen), 32'(expWr));
        if (wrSeen != 0) begin
            checkOutput("wr_addr", wrAddr, 32'(wordIdx));
            checkOutput("wr_data", wrData, expWord);
        end
        checkOutput("mem_word", memModel[wordIdx], expWord);
    endtask

    initial begin
        int strobesBefore;
        for (int i = 0; i < 65536; i++) memModel[i] = 32'd0;
        for (int i = 0; i < 16; i++) begin
            refMem[i] = $urandom;
            memModel[i] = refMem[i];
        end
        bus.req_valid = 1'b0;
        scrambleInputs();

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 32'd0);
        checkOutput("rst_misalign", 32'(bus.misalign), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.Mem_addr), 32'd0);
        checkOutput("rst_wr_data", bus.RF_Rd_data, 32'd0);
        checkOutput("rst_write_en", 32'(bus.CNTRL_write_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word store then word load at byte address 16.
        applyStimulus(1'b1, 2'b10, 1'b0, 16, 32'd20);
        applyStimulus(1'b0, 2'b10, 1'b0, 16, 32'd0);
        checkOutput("ex1_load", bus.resp_rdata, 32'd20);

        // Byte store into word 6 via read-modify-write.
        applyStimulus(1'b1, 2'b10, 1'b0, 24, 32'h0000_0005);
        applyStimulus(1'b1, 2'b00, 1'b0, 25, 32'h0000_00AB);
        checkOutput("ex2_word6", memModel[6], 32'h0000_AB05);

        // Signed/unsigned byte loads, half store and signed half load.
        applyStimulus(1'b0, 2'b00, 1'b1, 25, 32'd0);
        checkOutput("ex3_lb", bus.resp_rdata, 32'hFFFF_FFAB);
        applyStimulus(1'b0, 2'b00, 1'b0, 25, 32'd0);
        checkOutput("ex3_lbu", bus.resp_rdata, 32'h0000_00AB);
        applyStimulus(1'b1, 2'b01, 1'b0, 26, 32'h0000_8001);
        applyStimulus(1'b0, 2'b01, 1'b1, 26, 32'd0);
        checkOutput("ex3_lh", bus.resp_rdata, 32'hFFFF_8001);
        checkOutput("ex3_word6", memModel[6], 32'h8001_AB05);

        // Reset during CAPT of a byte store to word 7.
        applyStimulus(1'b1, 2'b10, 1'b0, 28, 32'd1);
        strobesBefore = strobeCount;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr = 18'd28;
        bus.req_wdata = 32'h0000_005A;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_capt_write_en", 32'(bus.CNTRL_write_en), 32'd0);
        checkOutput("rst_capt_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rst_capt_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        checkOutput("rst_capt_no_strobe", 32'(strobeCount - strobesBefore), 32'd0);
        checkOutput("rst_capt_word7", memModel[7], 32'd1);
        checkOutput("rst_capt_ready_after", 32'(bus.req_ready), 32'd1);

        // Reset while the write strobe is up: strobe must fall at once.
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b10;
        bus.req_addr = 18'd32;
        bus.req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        #1;
        checkOutput("wr_strobe_up", 32'(bus.CNTRL_write_en), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("wr_async_drop", 32'(bus.CNTRL_write_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("wr_rst_word8", memModel[8], refMem[8]);

        // Misaligned word load at byte address 30.
        applyStimulus(1'b0, 2'b10, 1'b0, 30, 32'd0);

        // Randomized traffic, mostly back-to-back.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                checkOutput("resp_pulse", 32'(bus.resp_valid), 32'd0);
            end
            applyStimulus(1'($urandom), 2'($urandom), 1'($urandom),
                          int'($urandom_range(0, 63)), $urandom);
        end

        for (int i = 0; i < 16; i++)
            checkOutput("final_mem", memModel[i], refMem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
